// File: rtl/note_sequencer_if.sv
// Key/button inputs and tone-generator outputs of note_sequencer.
// The sequencer takes the slave modport; whatever drives keys and buttons takes master.
interface note_sequencer_if #(
  parameter int NOTE_W    = 27,
  parameter int NUM_SLOTS = 5
);
  localparam int AS_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0] slot_btn;
  logic                 rec;
  logic [NOTE_W-1:0]    key;
  logic [NOTE_W-1:0]    note;
  logic                 playing;
  logic                 recording;
  logic [AS_W-1:0]      active_slot;
  logic                 done;

  modport master (
    output slot_btn, rec, key,
    input  note, playing, recording, active_slot, done
  );

  modport slave (
    input  slot_btn, rec, key,
    output note, playing, recording, active_slot, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Multi-slot note recorder/player: slot RAM, per-slot lengths, step-tick divider, IDLE/PLAY/REC FSM.
// Define NOTE_SEQUENCER_LOOP_EN to make playback wrap to word 0 at end of slot instead of stopping.
module note_sequencer #(
  parameter int NOTE_W    = 27,
  parameter int SLOT_W    = 10,
  parameter int NUM_SLOTS = 5,
  parameter int TICK_DIV  = 100000
) (
  input  logic            clk,
  input  logic            reset,
  note_sequencer_if.slave bus
);
  localparam int AS_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int DEPTH  = NUM_SLOTS * (2 ** SLOT_W);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TICK_DIV);

  localparam logic [SLOT_W:0]  LAST_PTR = {1'b0, {SLOT_W{1'b1}}};
  localparam logic [SLOT_W:0]  FULL_LEN = {1'b1, {SLOT_W{1'b0}}};
  localparam logic [SLOT_W:0]  PTR_ONE  = (SLOT_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_REC} state_e;

  state_e               state_q, state_d;
  logic [SLOT_W:0]      ptr_q, ptr_d;
  logic [AS_W-1:0]      slot_q, slot_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SLOT_W:0]      len_q [NUM_SLOTS];
  logic [SLOT_W:0]      len_d [NUM_SLOTS];
  logic                 done_q, done_d;
  logic [NUM_SLOTS-1:0] btn_q;
  logic [NOTE_W-1:0]    key_q;

  logic [NOTE_W-1:0]    mem [DEPTH];
  logic [NOTE_W-1:0]    rd_q;
  logic [ADDR_W-1:0]    addr;
  logic                 we;
  logic                 tick;

  logic [NUM_SLOTS-1:0] btn_rise;
  logic                 edge_any;
  logic [AS_W-1:0]      edge_idx;

  assign addr = ADDR_W'({slot_q, ptr_q[SLOT_W-1:0]});
  assign tick = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

  // Scanning from the top down leaves the lowest pressed index in edge_idx.
  always_comb begin
    btn_rise = bus.slot_btn & ~btn_q;
    edge_any = |btn_rise;
    edge_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (btn_rise[i]) edge_idx = AS_W'(i);
    end
  end

  // NOTE: reset is sampled on the clock edge here, and all state updates use non-blocking '<='.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      btn_q   <= '0;
      key_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      btn_q   <= bus.slot_btn;
      key_q   <= bus.key;
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= len_d[i];
    end
  end

  // NOTE: the note RAM has no reset so it can map onto block RAM; recorded contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= bus.key;
    rd_q <= mem[addr];
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    len_d   = len_q;
    done_d  = 1'b0;
    we      = 1'b0;
    cnt_d   = tick ? '0 : cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (edge_any) begin
          if (bus.rec) begin
            state_d = S_REC;
            slot_d  = edge_idx;
            ptr_d   = '0;
          end else if (len_q[edge_idx] != '0) begin
            state_d = S_PLAY;
            slot_d  = edge_idx;
            ptr_d   = '0;
          end
        end
      end

      S_REC: begin
        // Dropping rec wins over a coincident tick: that tick's word is not written.
        if (!bus.rec) begin
          len_d[slot_q] = ptr_q;
          state_d       = S_IDLE;
          done_d        = 1'b1;
        end else if (tick) begin
          we    = 1'b1;
          ptr_d = ptr_q + PTR_ONE;
          if (ptr_q == LAST_PTR) begin
            len_d[slot_q] = FULL_LEN;
            state_d       = S_IDLE;
            done_d        = 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (edge_any && (edge_idx == slot_q)) begin
          state_d = S_IDLE;
        end else if (edge_any && (len_q[edge_idx] != '0)) begin
          slot_d = edge_idx;
          ptr_d  = '0;
          cnt_d  = '0;
        end else if (tick) begin
          if (ptr_q == len_q[slot_q] - PTR_ONE) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
            ptr_d  = '0;
            done_d = 1'b1;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Entering or restarting a state always begins a fresh TICK_DIV period.
    if (state_d != state_q || state_d == S_IDLE) cnt_d = '0;
  end

  always_comb begin
    bus.playing     = (state_q == S_PLAY);
    bus.recording   = (state_q == S_REC);
    bus.active_slot = slot_q;
    bus.done        = done_q;
    case (state_q)
      S_PLAY:  bus.note = rd_q;
      S_REC:   bus.note = key_q;
      default: bus.note = '0;
    endcase
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Directed table-driven bench for note_sequencer (NOTE_W=8, SLOT_W=3, NUM_SLOTS=2, TICK_DIV=4).
// Expectations follow NOTE_SEQUENCER_LOOP_EN when it is defined for the build.
module tb_note_sequencer;
  logic clk = 1'b0;
  logic reset;

  note_sequencer_if #(.NOTE_W(8), .NUM_SLOTS(2)) bus ();

  note_sequencer #(
    .NOTE_W(8), .SLOT_W(3), .NUM_SLOTS(2), .TICK_DIV(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // One record = inputs held for 'hold' cycles; outputs checked after every one of those edges.
  // note < 0 means the note is the stale read of the previous address and is not compared.
  typedef struct {
    int         hold;
    logic [1:0] btn;
    logic       rec;
    logic [7:0] key;
    int         note;
    logic       pl;
    logic       rc;
    logic       as;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int hold, input logic [1:0] btn, input logic rec,
                              input logic [7:0] key, input int note, input logic pl,
                              input logic rc, input logic as, input logic dn);
    vec_t t;
    t.hold = hold; t.btn = btn; t.rec = rec; t.key = key; t.note = note;
    t.pl = pl; t.rc = rc; t.as = as; t.dn = dn;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int note, input logic pl, input logic rc,
                           input logic as, input logic dn);
    if (note >= 0) check({name, "_note"}, 32'(bus.note), 32'(note));
    check({name, "_playing"},   32'(bus.playing),     32'(pl));
    check({name, "_recording"}, 32'(bus.recording),   32'(rc));
    check({name, "_slot"},      32'(bus.active_slot), 32'(as));
    check({name, "_done"},      32'(bus.done),        32'(dn));
  endtask

  task automatic drive(input logic [1:0] btn, input logic rec, input logic [7:0] key);
    bus.slot_btn = btn;
    bus.rec      = rec;
    bus.key      = key;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Empty-slot press, record 3 notes into slot 0, play them back.
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 2'b01, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 2'b01, 1'b1, 8'h11, 'h11,  1'b0, 1'b1, 1'b0, 1'b0);
    add(4, 2'b00, 1'b1, 8'h11, 'h11,  1'b0, 1'b1, 1'b0, 1'b0);
    add(4, 2'b00, 1'b1, 8'h22, 'h22,  1'b0, 1'b1, 1'b0, 1'b0);
    add(4, 2'b00, 1'b1, 8'h33, 'h33,  1'b0, 1'b1, 1'b0, 1'b0);
    add(1, 2'b00, 1'b0, 8'h33, 0,     1'b0, 1'b0, 1'b0, 1'b1);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 2'b01, 1'b0, 8'h00, -1,    1'b1, 1'b0, 1'b0, 1'b0);
    add(4, 2'b00, 1'b0, 8'h00, 'h11,  1'b1, 1'b0, 1'b0, 1'b0);
    add(4, 2'b00, 1'b0, 8'h00, 'h22,  1'b1, 1'b0, 1'b0, 1'b0);
    add(3, 2'b00, 1'b0, 8'h00, 'h33,  1'b1, 1'b0, 1'b0, 1'b0);
`ifdef NOTE_SEQUENCER_LOOP_EN
    add(1, 2'b00, 1'b0, 8'h00, 'h33,  1'b1, 1'b0, 1'b0, 1'b1);
    add(4, 2'b00, 1'b0, 8'h00, 'h11,  1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 2'b01, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
`else
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b1);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
`endif
    // Fill slot 1 until it auto-stops after 8 ticks; key A0+i lands in word i.
    add(1, 2'b10, 1'b1, 8'hA0, 'hA0,  1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      add((i == 7) ? 3 : 4, 2'b00, 1'b1, 8'(8'hA0 + i), 'hA0 + i, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1, 2'b00, 1'b1, 8'hA7, 0,     1'b0, 1'b0, 1'b1, 1'b1);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b1, 1'b0);
    // Slot 0 intact; switch to slot 1 mid-play, stop it, then a two-button press picks slot 0.
    add(1, 2'b01, 1'b0, 8'h00, -1,    1'b1, 1'b0, 1'b0, 1'b0);
    add(4, 2'b00, 1'b0, 8'h00, 'h11,  1'b1, 1'b0, 1'b0, 1'b0);
    add(4, 2'b00, 1'b0, 8'h00, 'h22,  1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 2'b10, 1'b0, 8'h00, -1,    1'b1, 1'b0, 1'b1, 1'b0);
    add(4, 2'b10, 1'b0, 8'h00, 'hA0,  1'b1, 1'b0, 1'b1, 1'b0);
    add(1, 2'b00, 1'b0, 8'h00, 'hA1,  1'b1, 1'b0, 1'b1, 1'b0);
    add(1, 2'b10, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b1, 1'b0);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b1, 1'b0);
    add(1, 2'b11, 1'b0, 8'h00, -1,    1'b1, 1'b0, 1'b0, 1'b0);
    add(4, 2'b11, 1'b0, 8'h00, 'h11,  1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 2'b00, 1'b0, 8'h00, 'h22,  1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 2'b01, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 2'b00, 1'b0, 8'h00, 0,     1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for two edges with buttons and rec active.
    reset = 1'b0;
    drive(2'b11, 1'b1, 8'h5A);
    repeat (2) begin
      @(negedge clk);
      check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    drive(2'b00, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].btn, vecs[i].rec, vecs[i].key);
      for (int c = 0; c < vecs[i].hold; c++) begin
        @(negedge clk);
        check_all($sformatf("v%0d_%0d", i, c), vecs[i].note, vecs[i].pl, vecs[i].rc,
                  vecs[i].as, vecs[i].dn);
      end
    end

    // Full slot 1 playback: eight words confirm the auto-stop stored length 8.
    drive(2'b10, 1'b0, 8'h00);
    @(negedge clk);
    check_all("s1_start", -1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < ((i == 7) ? 3 : 4); c++) begin
        @(negedge clk);
        check_all($sformatf("s1_w%0d_%0d", i, c), 'hA0 + i, 1'b1, 1'b0, 1'b1, 1'b0);
      end
    end
    @(negedge clk);
`ifdef NOTE_SEQUENCER_LOOP_EN
    check_all("s1_wrap", 'hA7, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_all("s1_wrap_w0", 'hA0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(2'b10, 1'b0, 8'h00);
    @(negedge clk);
    check_all("s1_stop", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 8'h00);
`else
    check_all("s1_end", 0, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    @(negedge clk);
    check_all("s1_idle", 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of recording slot 0 after two ticks clears every length.
    drive(2'b01, 1'b1, 8'h44);
    @(negedge clk);
    check_all("rec2_start", 'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 1'b1, 8'h44);
    repeat (8) @(negedge clk);
    check_all("rec2_mid", 'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_all("rec2_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(2'b00, 1'b0, 8'h00);
    @(negedge clk);
    check_all("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 8'h00);
    @(negedge clk);
    check_all("post_reset_s0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 8'h00);
    @(negedge clk);
    drive(2'b10, 1'b0, 8'h00);
    @(negedge clk);
    check_all("post_reset_s1", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 8'h00);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
